img_pixel_reader: RTL



---
 rtl/img_pkg.sv | 25 ++
 rtl/pix_fifo.sv | 61 ++++++
 rtl/img_pixel_reader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared constants for the image pixel reader: frame defaults, FSM encodings
// and grayscale formula selection/weights.
package img_pkg;

  localparam int unsigned IMG_WIDTH_DEF  = 160;
  localparam int unsigned IMG_HEIGHT_DEF = 148;
  localparam int unsigned CH_BITS_DEF    = 4;
  localparam int unsigned ADDR_W_DEF     = 15;
  localparam int unsigned MEM_LAT_DEF    = 1;

  localparam int unsigned GRAY_MEAN     = 0;
  localparam int unsigned GRAY_WEIGHTED = 1;

  localparam int unsigned GRAY_W_R = 77;
  localparam int unsigned GRAY_W_G = 150;
  localparam int unsigned GRAY_W_B = 29;

  localparam int unsigned STATE_W = 2;
  typedef logic [STATE_W-1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/pix_fifo.sv
// Small synchronous FIFO buffering read-return words ahead of the output stage.
// Non-power-of-two depths are supported by explicit pointer wrap.
module pix_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop) begin
        rd_q <= ptr_inc(rd_q);
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

endmodule

// File: rtl/img_pixel_reader.sv
// Frame reader: streams one frame out of the image ROM as expanded RGB plus gray
// over valid/ready, with raster coordinates and sof/eol/eof markers.
module img_pixel_reader
  import img_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF,
  parameter int unsigned CH_BITS    = CH_BITS_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
  parameter int unsigned GRAY_MODE  = GRAY_MEAN
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [3*CH_BITS-1:0]          mem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    red,
  output logic [7:0]                    green,
  output logic [7:0]                    blue,
  output logic [7:0]                    gray,
  output logic [$clog2(IMG_WIDTH)-1:0]  x,
  output logic [$clog2(IMG_HEIGHT)-1:0] y,
  output logic                          sof,
  output logic                          eol,
  output logic                          eof,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned XW         = $clog2(IMG_WIDTH);
  localparam int unsigned YW         = $clog2(IMG_HEIGHT);
  localparam int unsigned PIX_W      = 3*CH_BITS;
  localparam int unsigned SIZE       = IMG_WIDTH*IMG_HEIGHT;
  localparam int unsigned FIFO_DEPTH = MEM_LAT+2;
  localparam int unsigned FCW        = $clog2(FIFO_DEPTH+1);
  localparam int unsigned CRW        = FCW+1;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [MEM_LAT-1:0] pipe_q, pipe_d;
  logic [XW-1:0]      cx_q, cx_d, x_q, x_d;
  logic [YW-1:0]      cy_q, cy_d, y_q, y_d;
  logic [7:0]         red_q, red_d, green_q, green_d, blue_q, blue_d, gray_q, gray_d;
  logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [CRW-1:0]     inflight;
  logic               credit_ok, issue, load, pop, handshake;
  logic [PIX_W-1:0]   fifo_dout;
  logic               fifo_full, fifo_empty;
  logic [FCW-1:0]     fifo_count;
  logic [7:0]         hd_r, hd_g, hd_b, hd_gray;
  logic [9:0]         sum3;
  logic [15:0]        wsum;

  // Replicate the stored channel MSB-first to fill 8 bits.
  function automatic logic [7:0] expand(input logic [CH_BITS-1:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[7-i] = v[CH_BITS-1-(i % CH_BITS)];
    end
    return r;
  endfunction

  pix_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (pipe_q[MEM_LAT-1]),
    .pop     (pop),
    .din     (mem_rdata),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Colour expansion and grayscale of the FIFO head pixel.
  always_comb begin
    hd_r    = expand(fifo_dout[2*CH_BITS +: CH_BITS]);
    hd_g    = expand(fifo_dout[CH_BITS +: CH_BITS]);
    hd_b    = expand(fifo_dout[0 +: CH_BITS]);
    sum3    = 10'(hd_r) + 10'(hd_g) + 10'(hd_b);
    wsum    = 16'(GRAY_W_R) * 16'(hd_r) + 16'(GRAY_W_G) * 16'(hd_g) + 16'(GRAY_W_B) * 16'(hd_b);
    hd_gray = (GRAY_MODE == GRAY_WEIGHTED) ? 8'(wsum >> 8) : 8'(sum3 / 10'd3);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = valid_q;
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    gray_d  = gray_q;
    x_d     = x_q;
    y_d     = y_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    done_d  = 1'b0;
    issue   = 1'b0;

    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + CRW'(pipe_q[i]);
    end
    // Reads in flight plus buffered words never exceed the FIFO capacity.
    credit_ok = ((inflight + CRW'(fifo_count)) < CRW'(FIFO_DEPTH)) && !fifo_full;
    handshake = valid_q && out_ready;
    load      = !valid_q || out_ready;
    pop       = load && !fifo_empty;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          addr_d  = '0;
          cx_d    = '0;
          cy_d    = '0;
        end
      end
      ST_FETCH: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (addr_q == ADDR_W'(SIZE-1)) begin
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (handshake && eof_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pipe_d = (pipe_q << 1) | MEM_LAT'(issue);

    if (load) begin
      valid_d = !fifo_empty;
      if (!fifo_empty) begin
        red_d   = hd_r;
        green_d = hd_g;
        blue_d  = hd_b;
        gray_d  = hd_gray;
        x_d     = cx_q;
        y_d     = cy_q;
        sof_d   = (cx_q == '0) && (cy_q == '0);
        eol_d   = (cx_q == XW'(IMG_WIDTH-1));
        eof_d   = eol_d && (cy_q == YW'(IMG_HEIGHT-1));
        if (eol_d) begin
          cx_d = '0;
          cy_d = eof_d ? '0 : cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      pipe_q  <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      valid_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      gray_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pipe_q  <= pipe_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      valid_q <= valid_d;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      gray_q  <= gray_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr  = addr_q;
  assign out_valid = valid_q;
  assign red       = red_q;
  assign green     = green_q;
  assign blue      = blue_q;
  assign gray      = gray_q;
  assign x         = x_q;
  assign y         = y_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
